id_ex_operand_stage: RTL

//   ID/EX pipeline register plus EX-stage forwarding unit and operand muxes for the pipelined RV32 core.

---
 rtl/id_ex_operand_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register followed by the EX-stage forwarding unit and
//   ALU operand muxes of the pipelined RV32 core.
//
//   Ports
//     clk, rst_n                 core clock (rising edge), async active-low reset
//     StallE, FlushE             hold / bubble control for the ID/EX register
//     *_D                        decoded operands, indices and control from ID
//     ALUResult_M, Rd_M,
//     RegWrite_M                 MEM-stage forward source
//     Result_W, Rd_W, RegWrite_W WB-stage forward source
//     SrcA_E, SrcB_E             ALU operands after forwarding / immediate select
//     WriteData_E                forwarded rs2 value for stores
//     ForwardA_E, ForwardB_E     forward selects (10 = MEM, 01 = WB, 00 = register)
//     remaining *_E, ValidE      registered copies of the ID-stage values
module id_ex_operand_stage #(
  parameter int                DATA_W      = 32,
  parameter int                REG_AW      = 5,
  parameter int                CTRL_W      = 4,
  parameter logic [CTRL_W-1:0] NOP_ALUCTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] RD1_D,
  input  logic [DATA_W-1:0] RD2_D,
  input  logic [DATA_W-1:0] ImmExt_D,
  input  logic [DATA_W-1:0] PC_D,
  input  logic [DATA_W-1:0] PCPlus4_D,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rd_D,
  input  logic [CTRL_W-1:0] ALUControl_D,
  input  logic              ALUSrc_D,
  input  logic              RegWrite_D,
  input  logic              MemWrite_D,
  input  logic              Branch_D,
  input  logic              Jump_D,
  input  logic [1:0]        ResultSrc_D,
  input  logic [DATA_W-1:0] ALUResult_M,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic [DATA_W-1:0] Result_W,
  output logic [DATA_W-1:0] SrcA_E,
  output logic [DATA_W-1:0] SrcB_E,
  output logic [CTRL_W-1:0] ALUControl_E,
  output logic [DATA_W-1:0] WriteData_E,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic [REG_AW-1:0] Rs1_E,
  output logic [REG_AW-1:0] Rs2_E,
  output logic [REG_AW-1:0] Rd_E,
  output logic [DATA_W-1:0] PC_E,
  output logic [DATA_W-1:0] PCPlus4_E,
  output logic [DATA_W-1:0] ImmExt_E,
  output logic              RegWrite_E,
  output logic              MemWrite_E,
  output logic              Branch_E,
  output logic              Jump_E,
  output logic [1:0]        ResultSrc_E,
  output logic              ValidE
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pcplus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        result_src;
    logic              valid;
  } idex_t;

  idex_t idex_q, idex_d, bubble;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // Bubble matches the reset image so a flushed slot is indistinguishable
  // from a freshly reset one.
  always_comb begin
    bubble          = '0;
    bubble.alu_ctrl = NOP_ALUCTRL;
  end

  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = bubble;
    end else if (!StallE) begin
      idex_d.rd1        = RD1_D;
      idex_d.rd2        = RD2_D;
      idex_d.imm        = ImmExt_D;
      idex_d.pc         = PC_D;
      idex_d.pcplus4    = PCPlus4_D;
      idex_d.rs1        = Rs1_D;
      idex_d.rs2        = Rs2_D;
      idex_d.rd         = Rd_D;
      idex_d.alu_ctrl   = ALUControl_D;
      idex_d.alu_src    = ALUSrc_D;
      idex_d.reg_write  = RegWrite_D;
      idex_d.mem_write  = MemWrite_D;
      idex_d.branch     = Branch_D;
      idex_d.jump       = Jump_D;
      idex_d.result_src = ResultSrc_D;
      idex_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q          <= '0;
      idex_q.alu_ctrl <= NOP_ALUCTRL;
    end else begin
      idex_q <= idex_d;
    end
  end

  // MEM is checked first so the younger result wins when both stages
  // target the same register; x0 is never forwarded.
  always_comb begin
    ForwardA_E = 2'b00;
    if (RegWrite_M && (Rd_M != '0) && (Rd_M == idex_q.rs1)) begin
      ForwardA_E = 2'b10;
    end else if (RegWrite_W && (Rd_W != '0) && (Rd_W == idex_q.rs1)) begin
      ForwardA_E = 2'b01;
    end
  end

  always_comb begin
    ForwardB_E = 2'b00;
    if (RegWrite_M && (Rd_M != '0) && (Rd_M == idex_q.rs2)) begin
      ForwardB_E = 2'b10;
    end else if (RegWrite_W && (Rd_W != '0) && (Rd_W == idex_q.rs2)) begin
      ForwardB_E = 2'b01;
    end
  end

  always_comb begin
    case (ForwardA_E)
      2'b10:   fwd_a = ALUResult_M;
      2'b01:   fwd_a = Result_W;
      default: fwd_a = idex_q.rd1;
    endcase
    case (ForwardB_E)
      2'b10:   fwd_b = ALUResult_M;
      2'b01:   fwd_b = Result_W;
      default: fwd_b = idex_q.rd2;
    endcase
  end

  assign SrcA_E       = fwd_a;
  assign WriteData_E  = fwd_b;
  assign SrcB_E       = idex_q.alu_src ? idex_q.imm : fwd_b;
  assign ALUControl_E = idex_q.alu_ctrl;
  assign Rs1_E        = idex_q.rs1;
  assign Rs2_E        = idex_q.rs2;
  assign Rd_E         = idex_q.rd;
  assign PC_E         = idex_q.pc;
  assign PCPlus4_E    = idex_q.pcplus4;
  assign ImmExt_E     = idex_q.imm;
  assign RegWrite_E   = idex_q.reg_write;
  assign MemWrite_E   = idex_q.mem_write;
  assign Branch_E     = idex_q.branch;
  assign Jump_E       = idex_q.jump;
  assign ResultSrc_E  = idex_q.result_src;
  assign ValidE       = idex_q.valid;

endmodule
